piso_serializer: RTL
====================

# piso_serializer

Parallel-in serial-out serializer for the parallel word held by the upstream 4-bit parallel register. It accepts one WIDTH-bit word through a load/ready handshake, then shifts it out MSB-first one bit per accepted cycle on a serial valid/ready link. A bit counter and a small FSM sequence the transfer, and a completion pulse marks the last bit.

## Interface
- WIDTH, default 4: parallel word width, minimum 2.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-low.
- load  input  1  upstream word valid; the word is accepted only while ready=1.
- p_in  input  WIDTH  parallel word; sampled on the accepting edge.
- ready  output  1  block can accept a new word.
- s_out  output  1  current serial bit.
- s_valid  output  1  s_out holds a valid bit.
- s_ready  input  1  downstream accepts the bit this cycle.
- done  output  1  single-cycle pulse on the cycle the final bit (data or parity) is accepted.

## Operation
- FSM states are IDLE, SHIFT and PARITY. PARITY exists only with PISO_PARITY_EN defined.
- IDLE:
  - ready=1, s_valid=0.
  - On load=1 the FSM captures p_in into the shift register, sets bit count to WIDTH-1 and goes to SHIFT.
- SHIFT:
  - s_valid=1 and s_out = shreg[WIDTH-1].
  - On s_ready=1 the register shifts left with zero fill and the count decrements.
  - On s_ready=0 the register, count and s_out hold. No bit is skipped or repeated.
  - When the count is 0 and s_ready=1:
    - Without parity: done=1 and the FSM goes to IDLE.
    - With parity: the FSM goes to PARITY.
- PARITY:
  - s_valid=1 and s_out = XOR of the captured word (even parity).
  - On s_ready=1: done=1 and the FSM goes to IDLE.
- load while ready=0 is ignored. Upstream must hold load and p_in until it sees ready=1.
- The counter is $clog2(WIDTH) bits wide and never wraps. SHIFT exits when the count reaches 0.
- Reset values:
  - FSM goes to IDLE.
  - ready=1, s_valid=0, s_out=0, done=0.
  - Shift register and counter clear to 0.
- Reset asserted mid-transfer aborts the word immediately. The word is not resumed and no done pulse is produced.

## Timing
- Accept edge: the clk edge with load=1 and ready=1. The first bit is presented on s_out with s_valid=1 in the following cycle.
- With s_ready held at 1:
  - Bits occupy WIDTH consecutive cycles, or WIDTH+1 with parity.
  - ready returns to 1 one cycle after done.
- Word-to-word throughput with no stalls is WIDTH+1 cycles, or WIDTH+2 with parity.
- ready, s_valid, s_out and done are registered or decoded from registered state only. There is no combinational path from load or p_in to any output.
- The only combinational input-to-output path is from s_ready to done.

## Configuration
- PISO_PARITY_EN:
  - Defined: the PARITY state is compiled in and one even-parity bit follows the data bits.
  - Undefined: no PARITY state and no parity logic. done coincides with acceptance of data bit 0.

## Structure
- Shared package piso_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - a localparam helper for the counter width, $clog2(WIDTH).
- One sub-module is natural: piso_bit_counter, a loadable down-counter with hold enable and a zero flag. It is instantiated once.
- The FSM, shift register and parity XOR stay in piso_serializer.

## Test plan
- Reset, no stimulus:
  - Hold rst=0 for 2 cycles, then release.
  - Required: ready=1, s_valid=0, s_out=0, done=0.
- Basic word, WIDTH=4, s_ready=1:
  - Load 4'b0101.
  - Required: s_out = 0,1,0,1 on cycles 1–4 after the accept edge; done=1 on cycle 4; ready=1 on cycle 5.
- Backpressure:
  - Load 4'b1100 and drop s_ready for 3 cycles after the first bit.
  - Required: s_out holds 1 with s_valid=1 through the stall; the full sequence is still 1,1,0,0; done fires once.
- Busy load:
  - Assert load with 4'b1111 during the SHIFT of 4'b0101.
  - Required: ignored; the output stays 0,1,0,1 and ready=0 until completion.
- Mid-transfer reset:
  - Assert rst after the second bit of 4'b1010.
  - Required: outputs go to reset values at once, no done pulse; after release a load of 4'b0011 gives 0,0,1,1.
- With PISO_PARITY_EN defined:
  - Load 4'b0111.
  - Required: s_out = 0,1,1,1 then parity 1; done is on the parity cycle.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and counter sizing.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Bit-counter width for a given word width; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with hold enable and zero flag; saturates at zero.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer, MSB first over a valid/ready link.
// Define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] p_in,
    output logic             ready,
    output logic             s_out,
    output logic             s_valid,
    input  logic             s_ready,
    output logic             done
);

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
`ifdef PISO_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    piso_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAST_IDX),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        done     = 1'b0;
        ready    = 1'b0;
        s_valid  = 1'b0;
        s_out    = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    shreg_d  = p_in;
                    cnt_load = 1'b1;
`ifdef PISO_PARITY_EN
                    parity_d = ^p_in;
`endif
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                s_valid = 1'b1;
                s_out   = shreg_q[WIDTH-1];
                if (s_ready) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_dec = 1'b1;
                    if (cnt_zero) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        done    = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                s_valid = 1'b1;
                s_out   = parity_q;
                if (s_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule
